// File: rtl/cnt_pkg.sv
// Shared constants for the multi-digit modulo counter.
// Digit width, size limits and direction encoding.
package cnt_pkg;

    localparam int DIGIT_W     = 4;
    localparam int MAX_DIGITS  = 8;
    localparam int MAX_MODULUS = 16;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/cnt_digit.sv
// One modulo-MODULUS digit cell with saturating load,
// up/down step and a direction-aware terminal flag.
module cnt_digit
    import cnt_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CLR,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               UP,
    input  logic [DIGIT_W-1:0] i_data,
    output logic [DIGIT_W-1:0] o_val,
    output logic               o_tc
);

    localparam logic [DIGIT_W-1:0] MAXV = DIGIT_W'(MODULUS - 1);
    localparam logic [DIGIT_W:0]   MODV = (DIGIT_W + 1)'(MODULUS);

    logic [DIGIT_W-1:0] r_val;
    logic [DIGIT_W-1:0] w_sat;
    logic [DIGIT_W-1:0] w_next;
    logic               w_up;

    assign w_up  = (UP == DIR_UP);
    assign w_sat = ({1'b0, i_data} >= MODV) ? MAXV : i_data;

    always_comb begin
        w_next = r_val;
        if (w_up)
            w_next = (r_val == MAXV) ? '0 : r_val + 1'b1;
        else
            w_next = (r_val == '0) ? MAXV : r_val - 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            r_val <= '0;
        else if (CLR)
            r_val <= '0;
        else if (i_load)
            r_val <= w_sat;
        else if (i_step)
            r_val <= w_next;
    end

    assign o_val = r_val;
    assign o_tc  = w_up ? (r_val == MAXV) : (r_val == '0);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit up/down modulo counter: chained digit cells,
// combinational terminal flags and a registered wrap pulse.
module bcd_updown_counter
    import cnt_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int MODULUS = 10
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic                      LOAD,
    input  logic                      CLR,
    input  logic                      UP,
    input  logic [DIGIT_W*DIGITS-1:0] DATA,
    output logic [DIGIT_W*DIGITS-1:0] DOUT,
    output logic [DIGITS-1:0]         DIGIT_TC,
    output logic                      COUNT,
    output logic                      WRAP
);

    logic              w_load;
    logic              w_cnt;
    logic [DIGITS-1:0] w_step;
    logic              r_wrap;

    assign w_load = EN & ~LOAD;
    assign w_cnt  = EN & LOAD;

    // a digit steps only when all lower digits sit at terminal
    assign w_step[0] = w_cnt;

    genvar g;
    generate
        for (g = 1; g < DIGITS; g++) begin : g_chain
            assign w_step[g] = w_step[g-1] & DIGIT_TC[g-1];
        end

        for (g = 0; g < DIGITS; g++) begin : g_digit
            cnt_digit #(
                .MODULUS (MODULUS)
            ) u_digit (
                .CLK    (CLK),
                .RST    (RST),
                .CLR    (CLR),
                .i_load (w_load),
                .i_step (w_step[g]),
                .UP     (UP),
                .i_data (DATA[g*DIGIT_W +: DIGIT_W]),
                .o_val  (DOUT[g*DIGIT_W +: DIGIT_W]),
                .o_tc   (DIGIT_TC[g])
            );
        end
    endgenerate

    assign COUNT = &DIGIT_TC;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            r_wrap <= 1'b0;
        else if (CLR)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_cnt & COUNT;
    end

    assign WRAP = r_wrap;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised and directed bench for bcd_updown_counter, checked
// against an integer-valued model of the whole counter.
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a, ld_a, clr_a, up_a;
    logic [15:0] data_a;
    logic [15:0] dout_a;
    logic [3:0]  tc_a;
    logic        cnt_a, wrap_a;

    logic        en_b, ld_b, clr_b, up_b;
    logic [7:0]  data_b;
    logic [7:0]  dout_b;
    logic [1:0]  tc_b;
    logic        cnt_b, wrap_b;

    int   va, vb;
    logic wa, wb;
    int   n_chk  = 0;
    int   n_fail = 0;

    bcd_updown_counter #(.DIGITS(4), .MODULUS(10)) u_dut_a (
        .CLK(clk), .RST(rst_n), .EN(en_a), .LOAD(ld_a), .CLR(clr_a),
        .UP(up_a), .DATA(data_a), .DOUT(dout_a), .DIGIT_TC(tc_a),
        .COUNT(cnt_a), .WRAP(wrap_a)
    );

    bcd_updown_counter #(.DIGITS(2), .MODULUS(6)) u_dut_b (
        .CLK(clk), .RST(rst_n), .EN(en_b), .LOAD(ld_b), .CLR(clr_b),
        .UP(up_b), .DATA(data_b), .DOUT(dout_b), .DIGIT_TC(tc_b),
        .COUNT(cnt_b), .WRAP(wrap_b)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pw(int m, int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * m;
        return r;
    endfunction

    function automatic logic [31:0] pack(int v, int m, int d);
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++)
            r[i*4 +: 4] = 4'((v / pw(m, i)) % m);
        return r;
    endfunction

    function automatic int sat_val(logic [31:0] data, int m, int d);
        int r = 0;
        int n;
        for (int i = 0; i < d; i++) begin
            n = int'(data[i*4 +: 4]);
            if (n > m - 1) n = m - 1;
            r = r + n * pw(m, i);
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_tc(int v, int m, int d, logic up);
        logic [31:0] r = '0;
        int dg;
        for (int i = 0; i < d; i++) begin
            dg = (v / pw(m, i)) % m;
            r[i] = up ? (dg == m - 1) : (dg == 0);
        end
        return r;
    endfunction

    function automatic void model(inout int v, inout logic w,
                                  input logic en, input logic ld,
                                  input logic clr, input logic up,
                                  input logic [31:0] data,
                                  input int m, input int d);
        int top = pw(m, d) - 1;
        if (clr) begin
            v = 0; w = 1'b0;
        end else if (en && !ld) begin
            v = sat_val(data, m, d); w = 1'b0;
        end else if (en) begin
            w = up ? (v == top) : (v == 0);
            if (up) v = (v == top) ? 0 : v + 1;
            else    v = (v == 0) ? top : v - 1;
        end else begin
            w = 1'b0;
        end
    endfunction

    task automatic check_all();
        logic [31:0] t;
        t = exp_tc(va, 10, 4, up_a);
        chk("a_dout", {16'h0, dout_a}, pack(va, 10, 4));
        chk("a_tc", {28'h0, tc_a}, t);
        chk("a_count", {31'h0, cnt_a}, {31'h0, &t[3:0]});
        chk("a_wrap", {31'h0, wrap_a}, {31'h0, wa});
        t = exp_tc(vb, 6, 2, up_b);
        chk("b_dout", {24'h0, dout_b}, pack(vb, 6, 2));
        chk("b_tc", {30'h0, tc_b}, t);
        chk("b_count", {31'h0, cnt_b}, {31'h0, &t[1:0]});
        chk("b_wrap", {31'h0, wrap_b}, {31'h0, wb});
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            va = 0; wa = 1'b0; vb = 0; wb = 1'b0;
        end else begin
            model(va, wa, en_a, ld_a, clr_a, up_a, {16'h0, data_a}, 10, 4);
            model(vb, wb, en_b, ld_b, clr_b, up_b, {24'h0, data_b}, 6, 2);
        end
        #1;
        check_all();
    endtask

    initial begin
        va = 0; vb = 0; wa = 1'b0; wb = 1'b0;
        rst_n = 1'b0;
        en_a = 1'b1; ld_a = 1'b1; clr_a = 1'b0; up_a = 1'b1; data_a = '0;
        en_b = 1'b0; ld_b = 1'b1; clr_b = 1'b0; up_b = 1'b1; data_b = '0;
        #2;
        check_all();
        tick();
        tick();
        chk("a_rst_dout", {16'h0, dout_a}, 32'h0);

        rst_n = 1'b1;
        repeat (5) tick();
        chk("a_five", {16'h0, dout_a}, 32'h0005);

        ld_a = 1'b0; data_a = 16'h9998;
        tick();
        ld_a = 1'b1; up_a = 1'b1;
        tick();
        chk("a_up_99", {16'h0, dout_a}, 32'h9999);
        chk("a_up_cnt", {31'h0, cnt_a}, 32'h1);
        tick();
        chk("a_up_wrap", {31'h0, wrap_a}, 32'h1);
        chk("a_up_zero", {16'h0, dout_a}, 32'h0);
        tick();
        chk("a_up_wrap_off", {31'h0, wrap_a}, 32'h0);

        ld_a = 1'b0; data_a = 16'h0001;
        tick();
        ld_a = 1'b1; up_a = 1'b0;
        tick();
        chk("a_dn_cnt", {31'h0, cnt_a}, 32'h1);
        tick();
        chk("a_dn_99", {16'h0, dout_a}, 32'h9999);
        chk("a_dn_wrap", {31'h0, wrap_a}, 32'h1);

        ld_a = 1'b0; data_a = 16'hAF12;
        tick();
        chk("a_sat", {16'h0, dout_a}, 32'h9912);
        en_a = 1'b0; data_a = 16'h1234;
        tick();
        chk("a_hold", {16'h0, dout_a}, 32'h9912);

        en_a = 1'b1; clr_a = 1'b1; data_a = 16'h5555;
        tick();
        chk("a_clr_ld", {16'h0, dout_a}, 32'h0);
        en_a = 1'b0;
        tick();
        chk("a_clr_noen", {16'h0, dout_a}, 32'h0);
        clr_a = 1'b0; ld_a = 1'b1;

        en_b = 1'b1; clr_b = 1'b1;
        tick();
        clr_b = 1'b0; up_b = 1'b1;
        repeat (35) tick();
        chk("b_55", {24'h0, dout_b}, 32'h55);
        tick();
        chk("b_wrap_zero", {24'h0, dout_b}, 32'h0);
        chk("b_wrap_pulse", {31'h0, wrap_b}, 32'h1);

        ld_b = 1'b0; data_b = 8'h23;
        tick();
        chk("b_ld23", {24'h0, dout_b}, 32'h23);
        ld_b = 1'b1; en_b = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        va = 0; wa = 1'b0; vb = 0; wb = 1'b0;
        chk("b_async_rst", {24'h0, dout_b}, 32'h0);
        check_all();
        tick();
        rst_n = 1'b1;
        en_b = 1'b1; up_b = 1'b0;
        tick();
        chk("b_rst_dn", {24'h0, dout_b}, 32'h55);
        chk("b_rst_dn_wrap", {31'h0, wrap_b}, 32'h1);

        for (int k = 0; k < 400; k++) begin
            en_a   = ($urandom_range(0, 7) != 0);
            ld_a   = ($urandom_range(0, 15) != 0);
            clr_a  = ($urandom_range(0, 31) == 0);
            up_a   = ($urandom_range(0, 63) == 0) ? ~up_a : up_a;
            data_a = 16'($urandom);
            en_b   = ($urandom_range(0, 7) != 0);
            ld_b   = ($urandom_range(0, 15) != 0);
            clr_b  = ($urandom_range(0, 31) == 0);
            up_b   = ($urandom_range(0, 31) == 0) ? ~up_b : up_b;
            data_b = 8'($urandom);
            #1;
            check_all();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
